bcd_countdown_timer_ctrl: RTL and testbench
===========================================

Name: bcd_countdown_timer_ctrl

Overview:
Parametrised successor of the MM:SS irrigation timer. Holds four BCD digits (minute tens/units, second tens/units) with an internal 1 Hz prescaler, a start/pause/expire state machine, up or down count mode and a built-in 4-digit 7-segment scan multiplexer. Sits between the irrigation controller (load/start/pause, done) and the board display.

Parameters:
TICK_DIV, 50000000, clk cycles per counted second (>=2)
SCAN_DIV, 50000, clk cycles per display digit slot (>=1)
MM_T_MAX, 5, max value of minute-tens digit (0..9); terminal up-count value is MM_T_MAX 9:59

Ports:
clk  in  1  system clock, rising edge
reset  in  1  synchronous, active-high
load  in  1  load preset digits, level sampled each edge
pre_mm_t  in  4  preset minute tens (BCD)
pre_mm_u  in  4  preset minute units
pre_ss_t  in  4  preset second tens
pre_ss_u  in  4  preset second units
start  in  1  run request
pause  in  1  pause request
up_mode  in  1  1 = count up, 0 = count down; sampled on each tick
mm_t, mm_u, ss_t, ss_u  out  4 each  current BCD digits (registered)
running  out  1  high in RUN
expired  out  1  high in EXPIRED
done  out  1  one-cycle pulse on entry to EXPIRED
seg  out  7  segments a..g = seg[0]..seg[6], active-high
digit_en  out  4  one-hot active-high digit select; bit0 = ss_u, bit1 = ss_t, bit2 = mm_u, bit3 = mm_t

Behaviour:
- Reset (sync, highest priority): digits 0, state IDLE, prescaler 0, scan counter 0, digit_en 4'b0001, seg 7'b0111111 ("0"), running/expired/done 0.
- States: IDLE, RUN, PAUSED, EXPIRED. Priority: reset > load > start/pause.
- load (any state): digits <= clamped presets, prescaler <= 0, state <= IDLE. Clamp: ss_t > 5 -> 5; units > 9 -> 9; mm_t > MM_T_MAX -> MM_T_MAX.
- IDLE/PAUSED + start: -> RUN, unless digits equal the terminal value for current up_mode (down: 00:00; up: MM_T_MAX 9:59), in which case start is ignored.
- RUN + pause: -> PAUSED; prescaler frozen, resumes from held value on start. start in RUN, pause outside RUN: ignored.
- Prescaler counts only in RUN, 0..TICK_DIV-1. Tick = prescaler == TICK_DIV-1; prescaler wraps to 0. First tick occurs TICK_DIV cycles after the edge that enters RUN from IDLE.
- On tick, digits update at that edge. Down: ss_u 0->9 with borrow, ss_t 0->5 with borrow, mm_u 0->9 with borrow, mm_t decrements. Up: ss_u 9->0 carry, ss_t 5->0 carry, mm_u 9->0 carry, mm_t increments.
- If the post-tick value equals terminal: same edge state <= EXPIRED. done high exactly the cycle after (first cycle of EXPIRED). expired held until load or reset; start/pause ignored in EXPIRED.
- Simultaneous load and tick: load wins, no count applied.
- up_mode change while RUN affects only subsequent ticks; terminal check uses up_mode at tick.
- Display: scan counter 0..SCAN_DIV-1 runs in every state (except reset). On wrap, digit index advances 0->1->2->3->0. digit_en and seg registered together, always consistent (seg encodes the digit selected by digit_en). Decoder: standard 0-9; codes > 9 impossible after clamping.

Test Plan:
- TICK_DIV=4, SCAN_DIV=2: reset -> digits 00:00, digit_en=0001, seg=0111111, all flags 0.
- Load 00:03, start, down -> 00:02/00:01/00:00 at cycles 4/8/12 after RUN entry; expired high, done single pulse on cycle 13, running 0.
- Load 01:00, start, down, one tick -> 00:59; load 7A:6F -> clamped to 59:59 (MM_T_MAX=5).
- Load 00:05, start, pause after 2 cycles, hold 10 cycles, start -> digits unchanged during pause; next tick 2 cycles after resume -> 00:04.
- up_mode=1, load 59:58, start -> 59:59 after 4 cycles, EXPIRED, done pulse; start in EXPIRED ignored; load 00:00 -> IDLE.
- Scan: digits 12:34 idle -> digit_en cycles 0001,0010,0100,1000 every 2 cycles with seg = "4","3","2","1"; load+tick same cycle -> load value, no decrement; reset mid-RUN -> full reset values next edge.

Source files
------------

// File: rtl/bcd_countdown_timer_ctrl.sv
// MM:SS BCD countdown/up-count timer with 1 Hz prescaler, run/pause/expire control
// and a free-running 4-digit 7-segment scan multiplexer.
module bcd_countdown_timer_ctrl #(
  parameter int TICK_DIV = 50000000,
  parameter int SCAN_DIV = 50000,
  parameter int MM_T_MAX = 5
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic [3:0] pre_mm_t,
  input  logic [3:0] pre_mm_u,
  input  logic [3:0] pre_ss_t,
  input  logic [3:0] pre_ss_u,
  input  logic       start,
  input  logic       pause,
  input  logic       up_mode,
  output logic [3:0] mm_t,
  output logic [3:0] mm_u,
  output logic [3:0] ss_t,
  output logic [3:0] ss_u,
  output logic       running,
  output logic       expired,
  output logic       done,
  output logic [6:0] seg,
  output logic [3:0] digit_en
);

  localparam int TICK_W = $clog2(TICK_DIV);
  localparam int SCAN_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [3:0] MMT_MAX = 4'(MM_T_MAX);

  typedef enum logic [1:0] {IDLE, RUN, PAUSED, EXPIRED} stateT;

  stateT stateReg, stateNext;
  logic [TICK_W-1:0] prescReg;
  logic [SCAN_W-1:0] scanReg;
  logic [1:0] idxReg, idxNext;
  logic [3:0] digReg [4];   // index 0 = ss_u .. 3 = mm_t
  logic [3:0] digNext [4];
  logic [3:0] stepDig [4];
  logic [3:0] preClamp [4];
  logic tick, scanWrap, stepTerminal, curTerminal, doneReg;
  logic [3:0] digitEnReg, digitEnNext;
  logic [6:0] segReg, segNext;

  function automatic logic isTerminal(input logic [3:0] d3, input logic [3:0] d2,
                                      input logic [3:0] d1, input logic [3:0] d0,
                                      input logic up);
    if (up)
      return (d3 == MMT_MAX) && (d2 == 4'd9) && (d1 == 4'd5) && (d0 == 4'd9);
    else
      return (d3 == 4'd0) && (d2 == 4'd0) && (d1 == 4'd0) && (d0 == 4'd0);
  endfunction

  function automatic logic [6:0] decode(input logic [3:0] d);
    case (d)
      4'd0: return 7'b0111111;
      4'd1: return 7'b0000110;
      4'd2: return 7'b1011011;
      4'd3: return 7'b1001111;
      4'd4: return 7'b1100110;
      4'd5: return 7'b1101101;
      4'd6: return 7'b1111101;
      4'd7: return 7'b0000111;
      4'd8: return 7'b1111111;
      4'd9: return 7'b1101111;
      default: return 7'b0000000;
    endcase
  endfunction

  assign tick = (stateReg == RUN) && (prescReg == TICK_W'(TICK_DIV - 1));

  always_comb begin
    preClamp[0] = (pre_ss_u > 4'd9) ? 4'd9 : pre_ss_u;
    preClamp[1] = (pre_ss_t > 4'd5) ? 4'd5 : pre_ss_t;
    preClamp[2] = (pre_mm_u > 4'd9) ? 4'd9 : pre_mm_u;
    preClamp[3] = (pre_mm_t > MMT_MAX) ? MMT_MAX : pre_mm_t;
  end

  // One-second step with ripple carry/borrow through the BCD digits
  always_comb begin
    stepDig[0] = digReg[0];
    stepDig[1] = digReg[1];
    stepDig[2] = digReg[2];
    stepDig[3] = digReg[3];
    if (up_mode) begin
      if (digReg[0] != 4'd9) stepDig[0] = digReg[0] + 4'd1;
      else begin
        stepDig[0] = 4'd0;
        if (digReg[1] != 4'd5) stepDig[1] = digReg[1] + 4'd1;
        else begin
          stepDig[1] = 4'd0;
          if (digReg[2] != 4'd9) stepDig[2] = digReg[2] + 4'd1;
          else begin
            stepDig[2] = 4'd0;
            stepDig[3] = (digReg[3] >= MMT_MAX) ? 4'd0 : digReg[3] + 4'd1;
          end
        end
      end
    end else begin
      if (digReg[0] != 4'd0) stepDig[0] = digReg[0] - 4'd1;
      else begin
        stepDig[0] = 4'd9;
        if (digReg[1] != 4'd0) stepDig[1] = digReg[1] - 4'd1;
        else begin
          stepDig[1] = 4'd5;
          if (digReg[2] != 4'd0) stepDig[2] = digReg[2] - 4'd1;
          else begin
            stepDig[2] = 4'd9;
            stepDig[3] = (digReg[3] == 4'd0) ? MMT_MAX : digReg[3] - 4'd1;
          end
        end
      end
    end
  end

  assign stepTerminal = isTerminal(stepDig[3], stepDig[2], stepDig[1], stepDig[0], up_mode);
  assign curTerminal  = isTerminal(digReg[3], digReg[2], digReg[1], digReg[0], up_mode);

  always_comb begin
    digNext[0] = digReg[0];
    digNext[1] = digReg[1];
    digNext[2] = digReg[2];
    digNext[3] = digReg[3];
    if (load) begin
      digNext[0] = preClamp[0];
      digNext[1] = preClamp[1];
      digNext[2] = preClamp[2];
      digNext[3] = preClamp[3];
    end else if (tick) begin
      digNext[0] = stepDig[0];
      digNext[1] = stepDig[1];
      digNext[2] = stepDig[2];
      digNext[3] = stepDig[3];
    end
  end

  // State register (done is registered on the transition into EXPIRED)
  always_ff @(posedge clk) begin
    if (reset) begin
      stateReg <= IDLE;
      doneReg  <= 1'b0;
    end else begin
      stateReg <= stateNext;
      doneReg  <= (stateNext == EXPIRED) && (stateReg != EXPIRED);
    end
  end

  always_comb begin
    stateNext = stateReg;
    if (load) begin
      stateNext = IDLE;
    end else begin
      case (stateReg)
        IDLE, PAUSED: if (start && !curTerminal) stateNext = RUN;
        RUN: begin
          if (tick && stepTerminal) stateNext = EXPIRED;
          else if (pause)           stateNext = PAUSED;
        end
        default: stateNext = stateReg;
      endcase
    end
  end

  always_comb begin
    running = (stateReg == RUN);
    expired = (stateReg == EXPIRED);
    done    = doneReg;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      digReg[0] <= 4'd0;
      digReg[1] <= 4'd0;
      digReg[2] <= 4'd0;
      digReg[3] <= 4'd0;
      prescReg  <= '0;
    end else begin
      digReg[0] <= digNext[0];
      digReg[1] <= digNext[1];
      digReg[2] <= digNext[2];
      digReg[3] <= digNext[3];
      if (load)                 prescReg <= '0;
      else if (tick)            prescReg <= '0;
      else if (stateReg == RUN) prescReg <= prescReg + TICK_W'(1);
    end
  end

  // Display scan; seg is built from next-cycle digits so it always matches digit_en
  assign scanWrap = (scanReg == SCAN_W'(SCAN_DIV - 1));
  assign idxNext  = scanWrap ? idxReg + 2'd1 : idxReg;
  assign segNext  = decode(digNext[idxNext]);

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : genDigitEn
      assign digitEnNext[gi] = (idxNext == 2'(gi));
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset) begin
      scanReg    <= '0;
      idxReg     <= 2'd0;
      digitEnReg <= 4'b0001;
      segReg     <= 7'b0111111;
    end else begin
      scanReg    <= scanWrap ? '0 : scanReg + SCAN_W'(1);
      idxReg     <= idxNext;
      digitEnReg <= digitEnNext;
      segReg     <= segNext;
    end
  end

  assign mm_t     = digReg[3];
  assign mm_u     = digReg[2];
  assign ss_t     = digReg[1];
  assign ss_u     = digReg[0];
  assign seg      = segReg;
  assign digit_en = digitEnReg;

endmodule

// File: tb/tb_bcd_countdown_timer_ctrl.sv
// Directed self-checking bench for bcd_countdown_timer_ctrl with TICK_DIV=4, SCAN_DIV=2.
module tb_bcd_countdown_timer_ctrl;
  logic clk = 1'b0;
  logic reset, load, start, pause, up_mode;
  logic [3:0] pre_mm_t, pre_mm_u, pre_ss_t, pre_ss_u;
  logic [3:0] mm_t, mm_u, ss_t, ss_u;
  logic running, expired, done;
  logic [6:0] seg;
  logic [3:0] digit_en;
  int nAsserts = 0;
  int nFails = 0;

  bcd_countdown_timer_ctrl #(.TICK_DIV(4), .SCAN_DIV(2), .MM_T_MAX(5)) dut (
    .clk(clk), .reset(reset), .load(load),
    .pre_mm_t(pre_mm_t), .pre_mm_u(pre_mm_u), .pre_ss_t(pre_ss_t), .pre_ss_u(pre_ss_u),
    .start(start), .pause(pause), .up_mode(up_mode),
    .mm_t(mm_t), .mm_u(mm_u), .ss_t(ss_t), .ss_u(ss_u),
    .running(running), .expired(expired), .done(done),
    .seg(seg), .digit_en(digit_en)
  );

  always #5 clk = ~clk;

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nAsserts++;
    assert (obs === exp) else begin
      nFails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chkDig(input string tag, input logic [15:0] exp);
    chk(tag, {16'd0, mm_t, mm_u, ss_t, ss_u}, {16'd0, exp});
  endtask

  task automatic doLoad(input logic [15:0] v);
    {pre_mm_t, pre_mm_u, pre_ss_t, pre_ss_u} = v;
    load = 1'b1;
    cyc(1);
    load = 1'b0;
  endtask

  task automatic doStart();
    start = 1'b1;
    cyc(1);
    start = 1'b0;
  endtask

  logic [3:0] expEn [4];
  logic [6:0] expSeg [4];

  initial begin
    reset = 1'b1; load = 1'b0; start = 1'b0; pause = 1'b0; up_mode = 1'b0;
    {pre_mm_t, pre_mm_u, pre_ss_t, pre_ss_u} = 16'h0000;
    cyc(2);
    chkDig("reset_digits", 16'h0000);
    chk("reset_digit_en", 32'(digit_en), 32'b0001);
    chk("reset_seg", 32'(seg), 32'b0111111);
    chk("reset_flags", 32'({running, expired, done}), 32'b000);
    reset = 1'b0;
    $display("reset state checked");

    // Down count 00:03 to expiry
    doLoad(16'h0003);
    chkDig("load_0003", 16'h0003);
    doStart();
    chk("run_entry", 32'(running), 32'd1);
    for (int i = 1; i <= 12; i++) begin
      cyc(1);
      if (i == 3)  chkDig("pre_tick1", 16'h0003);
      if (i == 4)  chkDig("tick1", 16'h0002);
      if (i == 8)  chkDig("tick2", 16'h0001);
      if (i == 11) chk("done_early", 32'(done), 32'd0);
    end
    chkDig("tick3", 16'h0000);
    chk("expired_set", 32'(expired), 32'd1);
    chk("done_pulse", 32'(done), 32'd1);
    chk("running_off", 32'(running), 32'd0);
    cyc(1);
    chk("done_single", 32'(done), 32'd0);
    chk("expired_hold", 32'(expired), 32'd1);
    $display("down count 00:03 -> expiry checked");

    // Borrow across minutes, then clamped load
    doLoad(16'h0100);
    doStart();
    cyc(4);
    chkDig("borrow_0059", 16'h0059);
    doLoad(16'h7A6F);
    chkDig("clamp_5959", 16'h5959);
    chk("load_stops_run", 32'(running), 32'd0);
    $display("borrow and clamp checked");

    // Pause and resume keeps prescaler phase
    doLoad(16'h0005);
    doStart();
    cyc(1);
    pause = 1'b1;
    cyc(1);
    pause = 1'b0;
    chk("paused", 32'(running), 32'd0);
    cyc(10);
    chkDig("pause_hold", 16'h0005);
    doStart();
    chk("resumed", 32'(running), 32'd1);
    cyc(1);
    chkDig("resume_pre", 16'h0005);
    cyc(1);
    chkDig("resume_tick", 16'h0004);
    $display("pause/resume checked");

    // Up count to terminal, start ignored in EXPIRED
    up_mode = 1'b1;
    doLoad(16'h5958);
    doStart();
    cyc(3);
    chkDig("up_pre", 16'h5958);
    cyc(1);
    chkDig("up_terminal", 16'h5959);
    chk("up_expired", 32'({expired, done}), 32'b11);
    doStart();
    chk("start_in_expired", 32'({running, expired, done}), 32'b010);
    doLoad(16'h0000);
    chk("load_clears_expired", 32'({running, expired}), 32'b00);
    up_mode = 1'b0;
    doStart();
    chk("start_at_down_terminal", 32'(running), 32'd0);
    up_mode = 1'b1;
    doStart();
    chk("start_up_from_zero", 32'(running), 32'd1);
    up_mode = 1'b0;
    $display("up count and terminal start checked");

    // Scan multiplexer with 12:34 idle
    doLoad(16'h1234);
    expEn[0] = 4'b0001; expSeg[0] = 7'b1100110;
    expEn[1] = 4'b0010; expSeg[1] = 7'b1001111;
    expEn[2] = 4'b0100; expSeg[2] = 7'b1011011;
    expEn[3] = 4'b1000; expSeg[3] = 7'b0000110;
    for (int w = 0; w < 20 && digit_en !== 4'b0001; w++) cyc(1);
    chk("scan_align", 32'(digit_en), 32'b0001);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("scan_en%0d", k), 32'(digit_en), 32'(expEn[k]));
      chk($sformatf("scan_seg%0d", k), 32'(seg), 32'(expSeg[k]));
      cyc(2);
    end
    $display("scan multiplexer checked");

    // Load on the tick edge wins
    doLoad(16'h0003);
    doStart();
    cyc(3);
    doLoad(16'h0007);
    chkDig("load_beats_tick", 16'h0007);
    chk("load_tick_idle", 32'(running), 32'd0);
    cyc(4);
    chkDig("load_tick_hold", 16'h0007);
    $display("load/tick collision checked");

    // Reset in the middle of RUN
    doLoad(16'h0010);
    doStart();
    cyc(4);
    chkDig("mid_run", 16'h0009);
    reset = 1'b1;
    cyc(1);
    chkDig("midrst_digits", 16'h0000);
    chk("midrst_flags", 32'({running, expired, done}), 32'b000);
    chk("midrst_en", 32'(digit_en), 32'b0001);
    chk("midrst_seg", 32'(seg), 32'b0111111);
    reset = 1'b0;
    $display("mid-run reset checked");

    $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFails);
    $finish;
  end
endmodule
